// File: rtl/object_catcher.sv
// rtl/object_catcher.sv - tracks falling objects from the spawner stream and judges catches/misses
// Spawns on idle->value edges into the lowest free slot; objects fall on a fixed cadence until judged.
module object_catcher #(
    parameter int unsigned UNDEFINED_POSITION = 1000,
    parameter int unsigned MAX_X              = 600,
    parameter int unsigned NUM_SLOTS          = 4,
    parameter int unsigned STEP_CYCLES        = 500000,
    parameter int unsigned FALL_STEP          = 4,
    parameter int unsigned CATCH_Y            = 440,
    parameter int unsigned CATCH_HALF_W       = 32,
    parameter int unsigned MAX_MISSES         = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [10:0]               object_position,
    input  logic [10:0]               player_x,
    output logic [NUM_SLOTS-1:0]      obj_valid,
    output logic [11*NUM_SLOTS-1:0]   obj_x,
    output logic [10*NUM_SLOTS-1:0]   obj_y,
    output logic [15:0]               score,
    output logic [7:0]                misses,
    output logic                      caught_pulse,
    output logic                      missed_pulse,
    output logic                      spawn_dropped,
    output logic                      game_over
);

    localparam int unsigned CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int unsigned IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int unsigned JC_W  = $clog2(NUM_SLOTS + 1);

    logic [NUM_SLOTS-1:0] valid_q, valid_d;
    logic [10:0]          x_q [NUM_SLOTS];
    logic [10:0]          x_d [NUM_SLOTS];
    logic [9:0]           y_q [NUM_SLOTS];
    logic [9:0]           y_d [NUM_SLOTS];
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [10:0]          prev_q, prev_d;
    logic [15:0]          score_q, score_d;
    logic [7:0]           misses_q, misses_d;
    logic                 caught_q, caught_d;
    logic                 missed_q, missed_d;
    logic                 dropped_q, dropped_d;
    logic                 over_q, over_d;

    logic                 step;
    logic                 spawn_evt;
    logic [10:0]          spawn_x;
    logic                 free_found;
    logic [IDX_W-1:0]     free_idx;
    logic [JC_W-1:0]      n_catch, n_miss;
    logic [10:0]          y_next;
    logic [11:0]          diff, abs_diff;
    logic [16:0]          score_sum;
    logic [8:0]           misses_sum;

    always_comb begin
        valid_d    = valid_q;
        x_d        = x_q;
        y_d        = y_q;
        cnt_d      = cnt_q;
        prev_d     = object_position;
        score_d    = score_q;
        misses_d   = misses_q;
        caught_d   = 1'b0;
        missed_d   = 1'b0;
        dropped_d  = 1'b0;
        over_d     = over_q | (misses_q >= 8'(MAX_MISSES));
        n_catch    = '0;
        n_miss     = '0;
        y_next     = '0;
        diff       = '0;
        abs_diff   = '0;
        score_sum  = '0;
        misses_sum = '0;

        step      = (cnt_q == CNT_W'(STEP_CYCLES - 1));
        spawn_evt = (object_position != 11'(UNDEFINED_POSITION)) &&
                    (prev_q == 11'(UNDEFINED_POSITION));
        spawn_x   = (object_position > 11'(MAX_X)) ? 11'(MAX_X) : object_position;

        // Free-slot search uses pre-step occupancy so a slot judged this cycle stays unavailable.
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end

        if (!over_q) begin
            cnt_d = step ? '0 : cnt_q + 1'b1;
            if (step) begin
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    if (valid_q[i]) begin
                        y_next = {1'b0, y_q[i]} + 11'(FALL_STEP);
                        if (y_next >= 11'(CATCH_Y)) begin
                            diff     = {1'b0, x_q[i]} - {1'b0, player_x};
                            abs_diff = diff[11] ? (~diff + 12'd1) : diff;
                            if (abs_diff <= 12'(CATCH_HALF_W)) begin
                                n_catch = n_catch + JC_W'(1);
                            end else begin
                                n_miss = n_miss + JC_W'(1);
                            end
                            valid_d[i] = 1'b0;
                            x_d[i]     = '0;
                            y_d[i]     = '0;
                        end else begin
                            y_d[i] = y_next[9:0];
                        end
                    end
                end
            end

            if (spawn_evt) begin
                if (free_found) begin
                    valid_d[free_idx] = 1'b1;
                    x_d[free_idx]     = spawn_x;
                    y_d[free_idx]     = '0;
                end else begin
                    dropped_d = 1'b1;
                end
            end

            score_sum  = {1'b0, score_q} + 17'(n_catch);
            misses_sum = {1'b0, misses_q} + 9'(n_miss);
            score_d    = score_sum[16] ? 16'hFFFF : score_sum[15:0];
            misses_d   = misses_sum[8] ? 8'hFF : misses_sum[7:0];
            caught_d   = (n_catch != '0);
            missed_d   = (n_miss != '0);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q   <= '0;
            cnt_q     <= '0;
            prev_q    <= 11'(UNDEFINED_POSITION);
            score_q   <= '0;
            misses_q  <= '0;
            caught_q  <= 1'b0;
            missed_q  <= 1'b0;
            dropped_q <= 1'b0;
            over_q    <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
            end
        end else begin
            valid_q   <= valid_d;
            cnt_q     <= cnt_d;
            prev_q    <= prev_d;
            score_q   <= score_d;
            misses_q  <= misses_d;
            caught_q  <= caught_d;
            missed_q  <= missed_d;
            dropped_q <= dropped_d;
            over_q    <= over_d;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                x_q[i] <= x_d[i];
                y_q[i] <= y_d[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_pack
        assign obj_x[11*g +: 11] = x_q[g];
        assign obj_y[10*g +: 10] = y_q[g];
    end

    assign obj_valid     = valid_q;
    assign score         = score_q;
    assign misses        = misses_q;
    assign caught_pulse  = caught_q;
    assign missed_pulse  = missed_q;
    assign spawn_dropped = dropped_q;
    assign game_over     = over_q;

endmodule

// File: doc/object_catcher.md
Name: object_catcher

Overview:
- Consumer of the spawner's `object_position` stream.
- Each valid spawn value becomes a falling object tracked in one of NUM_SLOTS slots.
- Objects descend on a fixed step cadence. At the catch line each object is judged against the player's x position and counted as a catch or a miss.
- Feeds the score display and the renderer, and asserts game_over after a miss limit.

Parameters:
- UNDEFINED_POSITION, 1000: input code meaning "no object this cycle".
- MAX_X, 600: largest legal x; larger spawn values are clamped to this.
- NUM_SLOTS, 4: number of objects tracked at once.
- STEP_CYCLES, 500000: clock cycles between fall steps.
- FALL_STEP, 4: pixels added to y per step.
- CATCH_Y, 440: y at or beyond which an object is judged.
- CATCH_HALF_W, 32: catch succeeds when |obj_x − player_x| ≤ this.
- MAX_MISSES, 8: miss count that asserts game_over.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: reset, asynchronous, active-low.
- object_position, input, 11: spawner output; UNDEFINED_POSITION when idle.
- player_x, input, 11: current player x, 0..MAX_X.
- obj_valid, output, NUM_SLOTS: per-slot active flag.
- obj_x, output, 11*NUM_SLOTS: slot i x in bits [11i+10:11i].
- obj_y, output, 10*NUM_SLOTS: slot i y in bits [10i+9:10i].
- score, output, 16: total catches, saturating at 65535.
- misses, output, 8: total misses, saturating at 255.
- caught_pulse, output, 1: one-cycle pulse when at least one catch is judged.
- missed_pulse, output, 1: one-cycle pulse when at least one miss is judged.
- spawn_dropped, output, 1: one-cycle pulse when a spawn is lost because all slots are full.
- game_over, output, 1: sticky flag, set when misses ≥ MAX_MISSES.

Behaviour:
- Reset (rst=0, asynchronous):
  - all outputs 0, all slots inactive, step counter 0;
  - prev-input register = UNDEFINED_POSITION;
  - applies immediately and overrides any in-flight step or spawn.
- Spawn detect:
  - prev register holds the last cycle's object_position.
  - A spawn event occurs when object_position ≠ UNDEFINED_POSITION and prev = UNDEFINED_POSITION.
  - A held non-idle value produces one spawn only. A value change without returning to idle produces none.
- Spawn x = min(object_position, MAX_X); any value 601..2047 except 1000 clamps to 600.
- Slot allocation:
  - lowest-index inactive slot takes the spawn, with y=0;
  - obj_valid, obj_x and obj_y are visible on the next cycle (1-cycle latency);
  - if no slot is free: spawn_dropped pulses for 1 cycle and state is unchanged.
- Step timer:
  - counts 0..STEP_CYCLES−1;
  - the step fires on the cycle the counter wraps to 0.
- On step, for each active slot, y_next = y + FALL_STEP (computed 11-bit, no wrap):
  - if y_next ≥ CATCH_Y, judge then free the slot (obj_valid=0, x and y cleared to 0);
  - otherwise y ← y_next.
- Judge:
  - compute diff = |obj_x − player_x| as 12-bit signed subtract, then absolute value, using player_x sampled on the step cycle;
  - diff ≤ CATCH_HALF_W → catch, otherwise → miss.
- Multiple judgements in one step:
  - score increases by the number of catches and misses by the number of misses (up to NUM_SLOTS each), both saturating;
  - each pulse asserts once regardless of count.
- Spawn and step in the same cycle:
  - existing slots step; the new slot is placed at y=0 and is not stepped that cycle;
  - a slot freed by judgement in that cycle is not available to the spawn until the next cycle.
- game_over:
  - set on the cycle after misses reaches ≥ MAX_MISSES;
  - once set, spawns are ignored (no spawn_dropped), the step timer halts, and slots and counters freeze;
  - clears only on reset.
- Pulses are registered outputs, high for exactly one clk.

Test Plan:
1. Reset low mid-fall (slot 0 at y=200) → all outputs 0 in the same cycle. After release with object_position=1000 held, no spawn occurs.
2. object_position 1000→300 held for 5 cycles, then 1000 → exactly one spawn: obj_valid=0001, obj_x[10:0]=300, y=0 one cycle after the edge.
3. Spawn value 850 → obj_x=600. Then spawn 1000→1000 (idle) → no spawn.
4. STEP_CYCLES=2, FALL_STEP=4, CATCH_Y=440:
   - object at x=300 with player_x=320 → caught after 110 steps; score=1, caught_pulse 1 cycle, slot freed.
   - repeat with player_x=340 (diff 40) → misses=1, missed_pulse.
5. Five spawn edges while no slot frees → slots 0..3 fill in order; the fifth edge gives a spawn_dropped pulse and obj_valid stays 1111.
6. MAX_MISSES=2, two objects missed in the same step → misses=2, single missed_pulse, game_over=1 next cycle. A later spawn edge leaves obj_valid=0000 and gives no spawn_dropped.
